clocking_in: RTL and testbench

Ingress stage of the FFT DMA path. Accepts one complex sample per beat from the DMA MM2S AXI-Stream and assembles FFT_SIZE samples into a full frame. Presents the frame as flat parallel real/imag vectors and pulses `start` to the FFT core when it is idle. The fill buffer is double-buffered against the output registers, so the next frame streams in while the FFT consumes the current one.

---
 rtl/fft_dma_pkg.sv | 18 +
 rtl/clocking_in_if.sv | 25 ++
 rtl/clocking_in.sv | 122 ++++++++++++
 tb/tb_clocking_in.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_dma_pkg.sv
// Shared definitions for the FFT DMA ingress/egress stages.
package fft_dma_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } cin_state_t;

  // Field positions inside an AXI-S beat: real in the low half, imag above it.
  localparam int unsigned TDATA_RE_FIELD = 0;
  localparam int unsigned TDATA_IM_FIELD = 1;

  // LSB of a tdata field for a given component width.
  function automatic int unsigned tdata_lsb(input int unsigned field, input int unsigned width);
    return field * width;
  endfunction

endpackage

// File: rtl/clocking_in_if.sv
// DMA stream and FFT-side signals of the clocking_in stage.
interface clocking_in_if #(
  parameter int unsigned FFT_SIZE = 8,
  parameter int unsigned WIDTH    = 18
);
  logic                      dma_tvalid;
  logic                      dma_tready;
  logic                      dma_tlast;
  logic [2*WIDTH-1:0]        dma_tdata;
  logic                      fft_ready;
  logic                      start;
  logic [FFT_SIZE*WIDTH-1:0] data_out_R;
  logic [FFT_SIZE*WIDTH-1:0] data_out_I;
  logic                      frame_err;

  modport master (
    output dma_tvalid, dma_tlast, dma_tdata, fft_ready,
    input  dma_tready, start, data_out_R, data_out_I, frame_err
  );

  modport slave (
    input  dma_tvalid, dma_tlast, dma_tdata, fft_ready,
    output dma_tready, start, data_out_R, data_out_I, frame_err
  );
endinterface

// File: rtl/clocking_in.sv
// FFT ingress: assembles FFT_SIZE stream samples into a frame, then hands the
// frame to the FFT core as flat real/imag vectors with a one-cycle start.
//
// state | meaning
// FILL  | accepting beats into the fill buffer
// FULL  | frame complete, waiting for fft_ready to publish it
module clocking_in
  import fft_dma_pkg::*;
#(
  parameter int unsigned FFT_SIZE     = 8,
  parameter int unsigned FFT_SIZE_LOG = 3,
  parameter int unsigned WIDTH        = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  clocking_in_if.slave  bus
);

  localparam int unsigned RE_LSB = tdata_lsb(TDATA_RE_FIELD, WIDTH);
  localparam int unsigned IM_LSB = tdata_lsb(TDATA_IM_FIELD, WIDTH);
  localparam logic [FFT_SIZE_LOG-1:0] IDX_LAST = FFT_SIZE_LOG'(FFT_SIZE - 1);

  cin_state_t              state_q, state_d;
  logic [FFT_SIZE_LOG-1:0] idx_q, idx_d;
  logic                    tready_q, tready_d;
  logic                    start_q, start_d;
  logic                    err_q, err_d;
  logic                    beat;
  logic                    load_out;

  logic [WIDTH-1:0]          buf_r_q [FFT_SIZE];
  logic [WIDTH-1:0]          buf_i_q [FFT_SIZE];
  logic [FFT_SIZE*WIDTH-1:0] out_r_q, out_i_q;

  // tready is registered, so it is only ever high while in FILL.
  assign beat = bus.dma_tvalid & tready_q;

  // State, index and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      idx_q    <= '0;
      tready_q <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tready_q <= tready_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  // Next state: frame completion, early/missing tlast, and hand-off to the FFT.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    start_d  = 1'b0;
    err_d    = 1'b0;
    load_out = 1'b0;
    case (state_q)
      FILL: begin
        if (beat) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = FULL;
            err_d   = ~bus.dma_tlast;
          end else if (bus.dma_tlast) begin
            // Short frame: drop it and restart at slot 0.
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + FFT_SIZE_LOG'(1);
          end
        end
      end
      FULL: begin
        if (bus.fft_ready) begin
          load_out = 1'b1;
          start_d  = 1'b1;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    tready_d = (state_d == FILL);
  end

  // Fill buffer: one sample written per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FFT_SIZE; k++) begin
        buf_r_q[k] <= '0;
        buf_i_q[k] <= '0;
      end
    end else if (beat) begin
      buf_r_q[idx_q] <= bus.dma_tdata[RE_LSB +: WIDTH];
      buf_i_q[idx_q] <= bus.dma_tdata[IM_LSB +: WIDTH];
    end
  end

  // Output registers: only updated on the edge that raises start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r_q <= '0;
      out_i_q <= '0;
    end else if (load_out) begin
      for (int k = 0; k < FFT_SIZE; k++) begin
        out_r_q[k*WIDTH +: WIDTH] <= buf_r_q[k];
        out_i_q[k*WIDTH +: WIDTH] <= buf_i_q[k];
      end
    end
  end

  assign bus.dma_tready = tready_q;
  assign bus.start      = start_q;
  assign bus.frame_err  = err_q;
  assign bus.data_out_R = out_r_q;
  assign bus.data_out_I = out_i_q;

endmodule

// File: tb/tb_clocking_in.sv
// Directed bench for clocking_in: frame assembly, back-pressure, tlast errors, reset.
module tb_clocking_in;

  localparam int N = 8;
  localparam int L = 3;
  localparam int W = 18;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   s1;

  clocking_in_if #(.FFT_SIZE(N), .WIDTH(W)) bus ();

  clocking_in #(.FFT_SIZE(N), .FFT_SIZE_LOG(L), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N*W-1:0] exp_r(input int base);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_i(input int base);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(-(base + k));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives nbeats beats of sample base+k (imag = -(base+k)) back to back,
  // tlast on beat index last_at; leaves tvalid low afterwards.
  task automatic send_frame(input int base, input int last_at, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      chk("tready_beat", {{(N*W-1){1'b0}}, bus.dma_tready}, 1);
      bus.dma_tdata  = {W'(-(base + k)), W'(base + k)};
      bus.dma_tlast  = (k == last_at);
      bus.dma_tvalid = 1'b1;
      @(negedge clk);
    end
    bus.dma_tvalid = 1'b0;
    bus.dma_tlast  = 1'b0;
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_err = 0; s1 = 0;
    rst_n = 1'b0;
    bus.dma_tvalid = 1'b0;
    bus.dma_tlast  = 1'b0;
    bus.dma_tdata  = '0;
    bus.fft_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", bus.dma_tready, 0);
    chk("rst_start",  bus.start, 0);
    chk("rst_err",    bus.frame_err, 0);
    chk("rst_out_r",  bus.data_out_R, 0);
    chk("rst_out_i",  bus.data_out_I, 0);
    bus.dma_tvalid = 1'b1;
    bus.dma_tdata  = {W'(0), W'(0)};
    rst_n = 1'b1;
    #1 chk("tready_pre_edge", bus.dma_tready, 0);
    @(negedge clk);

    // First frame: real=k, imag=-k
    send_frame(0, 7, 8);
    chk("f1_full_tready", bus.dma_tready, 0);
    chk("f1_full_start",  bus.start, 0);
    chk("f1_full_err",    bus.frame_err, 0);
    @(negedge clk);
    chk("f1_start",  bus.start, 1);
    chk("f1_out_r",  bus.data_out_R, exp_r(0));
    chk("f1_out_i",  bus.data_out_I, exp_i(0));
    chk("f1_err",    bus.frame_err, 0);
    chk("f1_tready", bus.dma_tready, 1);
    s1 = cyc;

    // Back-to-back second frame
    send_frame(16, 7, 8);
    chk("f2_hold_out_r", bus.data_out_R, exp_r(0));
    chk("f2_full_start", bus.start, 0);
    chk("f2_full_tready", bus.dma_tready, 0);
    @(negedge clk);
    chk("f2_start",  bus.start, 1);
    chk("f2_out_r",  bus.data_out_R, exp_r(16));
    chk("f2_out_i",  bus.data_out_I, exp_i(16));
    chk("f2_period", cyc - s1, 9);

    // FFT busy for 20 cycles; stream keeps offering a beat that must not land
    bus.fft_ready = 1'b0;
    send_frame(32, 7, 8);
    bus.dma_tvalid = 1'b1;
    bus.dma_tdata  = '1;
    for (int i = 0; i < 20; i++) begin
      chk("busy_tready", bus.dma_tready, 0);
      chk("busy_start",  bus.start, 0);
      chk("busy_out_r",  bus.data_out_R, exp_r(16));
      @(negedge clk);
    end
    bus.fft_ready = 1'b1;
    @(negedge clk);
    chk("f3_start", bus.start, 1);
    chk("f3_out_r", bus.data_out_R, exp_r(32));
    chk("f3_out_i", bus.data_out_I, exp_i(32));

    // Early tlast on beat 3
    send_frame(48, 3, 4);
    chk("early_err",    bus.frame_err, 1);
    chk("early_start",  bus.start, 0);
    chk("early_tready", bus.dma_tready, 1);
    chk("early_out_r",  bus.data_out_R, exp_r(32));
    @(negedge clk);
    chk("early_err_clr", bus.frame_err, 0);
    chk("early_start2",  bus.start, 0);
    send_frame(64, 7, 8);
    chk("f4_full_start", bus.start, 0);
    @(negedge clk);
    chk("f4_start", bus.start, 1);
    chk("f4_out_r", bus.data_out_R, exp_r(64));
    chk("f4_out_i", bus.data_out_I, exp_i(64));
    chk("f4_err",   bus.frame_err, 0);

    // Missing tlast on beat 7: error right after the beat, frame still issued
    send_frame(80, -1, 8);
    chk("miss_err",    bus.frame_err, 1);
    chk("miss_tready", bus.dma_tready, 0);
    @(negedge clk);
    chk("miss_start",   bus.start, 1);
    chk("miss_err_clr", bus.frame_err, 0);
    chk("miss_out_r",   bus.data_out_R, exp_r(80));
    chk("miss_out_i",   bus.data_out_I, exp_i(80));

    // Reset after beat 4 of a frame
    send_frame(96, 7, 5);
    rst_n = 1'b0;
    #1;
    chk("rst4_tready", bus.dma_tready, 0);
    chk("rst4_start",  bus.start, 0);
    chk("rst4_err",    bus.frame_err, 0);
    chk("rst4_out_r",  bus.data_out_R, 0);
    chk("rst4_out_i",  bus.data_out_I, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(112, 7, 8);
    @(negedge clk);
    chk("f5_start", bus.start, 1);
    chk("f5_out_r", bus.data_out_R, exp_r(112));
    chk("f5_out_i", bus.data_out_I, exp_i(112));

    // Reset while FULL: pending frame dropped, no start
    bus.fft_ready = 1'b0;
    send_frame(128, 7, 8);
    chk("rstf_full_tready", bus.dma_tready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstf_tready", bus.dma_tready, 0);
    chk("rstf_start",  bus.start, 0);
    chk("rstf_out_r",  bus.data_out_R, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.fft_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstf_no_start", bus.start, 0);
      chk("rstf_idle_tready", bus.dma_tready, 1);
      chk("rstf_idle_out_r", bus.data_out_R, 0);
    end

    // Idle FILL cycles above must not have moved idx: next frame lands at slot 0
    send_frame(144, 7, 8);
    @(negedge clk);
    chk("f6_start", bus.start, 1);
    chk("f6_out_r", bus.data_out_R, exp_r(144));
    chk("f6_out_i", bus.data_out_I, exp_i(144));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
